mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

MEM-stage data-memory access controller for the five-stage MIPS core. It turns load/store instructions into single transactions on the SRAM-like data bus and drives byte/halfword sizes, write strobes and replicated write data. It stalls the pipeline until the transaction completes and returns the raw 32-bit read word, which the downstream load extractor narrows by opcode and address. It also detects misaligned addresses (AdEL/AdES) before any bus activity.

## Interface
- No parameters; opcode encodings come from the `op_*` macros in `defines.vh`.
- clk  in  1  core clock; all state changes on rising edge
- resetn  in  1  synchronous reset, active-low
- memenM  in  1  MEM-stage instruction is a load or store
- memwriteM  in  1  1 = store, 0 = load
- opM  in  6  MEM-stage opcode (LB/LBU/LH/LHU/LW/SB/SH/SW)
- aluoutM  in  32  effective address
- writedataM  in  32  store source register value
- flushM  in  1  exception/flush kills the MEM-stage instruction
- stallM  out  1  hold the pipeline at/behind MEM
- readdataM  out  32  raw bus word captured for the completed load
- adelM  out  1  load address error
- adesM  out  1  store address error
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  byte address
- data_wdata  out  32  write data, lane-replicated
- data_wstrb  out  4  byte enables
- data_addr_ok  in  1  slave accepted the address phase
- data_data_ok  in  1  slave completed the data phase
- data_rdata  in  32  read data, valid with data_data_ok

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: if memenM && !flushM && no address error, latch wr, size, address, wdata and wstrb into registers, then go to ADDR. Otherwise stay in IDLE.
- ADDR: data_req=1 and bus outputs come from the latched registers.
  - addr_ok && data_ok in the same cycle: go to DONE.
  - addr_ok alone: go to DATA.
  - flushM && !addr_ok: abandon the request and go to IDLE.
- DATA: data_req=0. On data_ok go to DONE; flushM is ignored here because the transaction is already committed.
- DONE: one cycle, stallM=0, pipeline advances. Next state is IDLE unconditionally.
- readdataM is loaded from data_rdata on every data_ok accepted by a load. It holds its value otherwise.
- stallM = (IDLE && memenM && !flushM && !exc) || ADDR || DATA.
- Size and strobes are computed from a = aluoutM[1:0]:
  - LB/LBU/SB: size 0, wstrb = 1<<a.
  - LH/LHU/SH: size 1, wstrb = 0011 (a=00) or 1100 (a=10).
  - LW/SW: size 2, wstrb = 1111.
  - Loads drive wstrb=0000.
- Write data lanes: SB → {4{wd[7:0]}}, SH → {2{wd[15:0]}}, SW → wd.
- Misalignment: halfword with a[0]=1, or word with a≠00.
  - Load: adelM=1; store: adesM=1.
  - Error flags are combinational in IDLE and suppressed by flushM.
  - No bus request is issued and there is no stall.
- Unknown opcodes with memenM=1 are treated as LW/SW.

## Timing
- Reset (resetn=0 at a clock edge) forces:
  - state=IDLE, readdataM=0.
  - All latched bus registers to 0, so data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_wstrb=0.
  - Outputs stallM=0, adelM=0, adesM=0.
- Reset mid-transaction abandons it; a late data_ok while in IDLE is ignored.
- Minimum latency (zero-wait slave, addr_ok and data_ok in ADDR): stallM high 2 cycles (IDLE, ADDR), DONE on the 3rd.
- Each extra addr_ok wait adds one ADDR cycle. Each extra data_ok wait adds one DATA cycle.
- Bus outputs are stable for the whole ADDR residency and never change while data_req=1.
- Exactly one outstanding transaction at any time.
- Back-to-back memory instructions: DONE → IDLE → ADDR. The minimum issue interval is 3 cycles.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: misalignment detection and AdEL/AdES behave as specified above.
- Not defined:
  - adelM and adesM are tied to 0.
  - Misaligned accesses are force-aligned: data_addr[1:0]=00 for word, data_addr[0]=0 for halfword; wstrb and size use the aligned address.
  - The transaction is issued normally.

## Test plan
- LW at 0x0000_0100, slave addr_ok and data_ok in the first ADDR cycle, rdata=0xDEADBEEF → stallM high 2 cycles; readdataM=0xDEADBEEF in DONE; size=2; wstrb=0000.
- SB at 0x0000_0103, writedata=0x1234_5678, addr_ok delayed 3 cycles → data_req held 4 cycles with wdata=0x7878_7878, wstrb=1000, size=0, data_wr=1; DONE one cycle after data_ok.
- LH at 0x0000_0201 with the macro defined → adelM=1, data_req never asserted, stallM=0. Without the macro → data_addr=0x0000_0200, size=1.
- flushM in ADDR before addr_ok → data_req drops next cycle, back to IDLE. flushM in DATA → FSM still waits for data_ok, then DONE.
- resetn low during DATA → next cycle state IDLE, all outputs 0; a late data_ok (rdata=0xFFFF_FFFF) leaves readdataM=0.
- Back-to-back SW 0x10 then LBU 0x11, zero-wait slave → second data_req rises exactly 3 cycles after the first; strobes 1111 then 0000.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: SRAM-like data bus between the MEM-stage access
// controller (master) and the data memory (slave).
//
// Handshake: the master holds data_req and every request field stable
// until the slave answers with data_addr_ok. data_data_ok then
// completes the transaction, either in the same cycle or in a later one.
// data_rdata is valid only in a cycle where data_data_ok is high. At most
// one transaction is outstanding at any time.
interface mem_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller for the
// five-stage MIPS core. It issues one bus transaction per load/store,
// stalls the pipeline until the transaction completes and returns the raw
// read word.
//
// Build option: MEM_ALIGN_CHECK_EN
//   defined   - misaligned halfword/word accesses raise adelM/adesM and
//               no bus transaction is issued.
//   undefined - adelM/adesM stay 0 and misaligned addresses are
//               force-aligned before the transaction is issued.
module mem_access_ctrl (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      memenM,
    input  logic                      memwriteM,
    input  logic [5:0]                opM,
    input  logic [31:0]               aluoutM,
    input  logic [31:0]               writedataM,
    input  logic                      flushM,
    output logic                      stallM,
    output logic [31:0]               readdataM,
    output logic                      adelM,
    output logic                      adesM,
    output logic [1:0]                dbg_state_o,
    mem_access_ctrl_if.master         bus
);

    // Standard MIPS I load/store opcodes.
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] readdata_q;

    logic [1:0]  size_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;
    logic        misalign;
    logic        addr_err;
    logic        in_idle_req;
    logic        issue;

    // Decode size, aligned address, strobes and replicated write data from the MEM-stage instruction.
    always_comb begin
        size_d = 2'd2;
        case (opM)
            OP_LB, OP_LBU, OP_SB: size_d = 2'd0;
            OP_LH, OP_LHU, OP_SH: size_d = 2'd1;
            OP_LW, OP_SW:         size_d = 2'd2;
            default:              size_d = 2'd2; // unknown opcodes act as word accesses
        endcase

        misalign = ((size_d == 2'd1) && aluoutM[0]) ||
                   ((size_d == 2'd2) && (aluoutM[1:0] != 2'b00));

        // Only reachable for a misaligned address when the check is compiled out.
        addr_d = aluoutM;
        if (size_d == 2'd1) begin
            addr_d[0] = 1'b0;
        end else if (size_d == 2'd2) begin
            addr_d[1:0] = 2'b00;
        end

        wstrb_d = 4'b0000;
        if (memwriteM) begin
            case (size_d)
                2'd0:    wstrb_d = 4'b0001 << addr_d[1:0];
                2'd1:    wstrb_d = addr_d[1] ? 4'b1100 : 4'b0011;
                default: wstrb_d = 4'b1111;
            endcase
        end

        case (size_d)
            2'd0:    wdata_d = {4{writedataM[7:0]}};
            2'd1:    wdata_d = {2{writedataM[15:0]}};
            default: wdata_d = writedataM;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_err = misalign;
`else
    assign addr_err = 1'b0;
`endif

    // A live, unflushed memory instruction waiting in IDLE.
    assign in_idle_req = (state_q == ST_IDLE) && memenM && !flushM;
    assign issue       = in_idle_req && !addr_err;

    assign adelM  = in_idle_req && addr_err && !memwriteM;
    assign adesM  = in_idle_req && addr_err &&  memwriteM;
    assign stallM = issue || (state_q == ST_ADDR) || (state_q == ST_DATA);

    assign readdataM   = readdata_q;
    assign dbg_state_o = state_q;

    // The request is only driven in ADDR; all fields come from the latched registers so they cannot move while data_req=1.
    assign bus.data_req   = (state_q == ST_ADDR);
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign bus.data_wstrb = wstrb_q;

    // Transaction FSM: latch the request in IDLE, hold it through ADDR, wait out DATA, release the pipeline in DONE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            readdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        wr_q    <= memwriteM;
                        size_q  <= size_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        wstrb_q <= wstrb_d;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.data_addr_ok && bus.data_data_ok) begin
                        if (!wr_q) begin
                            readdata_q <= bus.data_rdata;
                        end
                        state_q <= ST_DONE;
                    end else if (bus.data_addr_ok) begin
                        state_q <= ST_DATA;
                    end else if (flushM) begin
                        // Slave never saw the address, so the request can be dropped.
                        state_q <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // Committed transaction: a flush cannot cancel it.
                    if (bus.data_data_ok) begin
                        if (!wr_q) begin
                            readdata_q <= bus.data_rdata;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against
// hand-computed bus values, stall timing and read data.
module tb_mem_access_ctrl;

    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic        clk;
    logic        resetn;
    logic        memenM;
    logic        memwriteM;
    logic [5:0]  opM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        stallM;
    logic [31:0] readdataM;
    logic        adelM;
    logic        adesM;
    logic [1:0]  dbg_state;

    int total;
    int bad;
    int cyc;
    int req_cyc1;
    int req_cyc2;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .memenM      (memenM),
        .memwriteM   (memwriteM),
        .opM         (opM),
        .aluoutM     (aluoutM),
        .writedataM  (writedataM),
        .flushM      (flushM),
        .stallM      (stallM),
        .readdataM   (readdataM),
        .adelM       (adelM),
        .adesM       (adesM),
        .dbg_state_o (dbg_state),
        .bus         (bus)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem(input logic wr, input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] wd);
        memenM     = 1'b1;
        memwriteM  = wr;
        opM        = op;
        aluoutM    = addr;
        writedataM = wd;
    endtask

    task automatic slave(input logic aok, input logic dok, input logic [31:0] rd);
        bus.data_addr_ok = aok;
        bus.data_data_ok = dok;
        bus.data_rdata   = rd;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        resetn     = 1'b0;
        memenM     = 1'b0;
        memwriteM  = 1'b0;
        opM        = 6'd0;
        aluoutM    = 32'd0;
        writedataM = 32'd0;
        flushM     = 1'b0;
        slave(1'b0, 1'b0, 32'd0);

        // reset state
        tick();
        tick();
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_req", 32'(bus.data_req), 32'd0);
        check("rst_bus", {bus.data_wr, bus.data_size, bus.data_wstrb}, 32'd0);
        check("rst_addr", bus.data_addr, 32'd0);
        check("rst_wdata", bus.data_wdata, 32'd0);
        check("rst_rdata", readdataM, 32'd0);
        check("rst_flags", {stallM, adelM, adesM}, 32'd0);
        resetn = 1'b1;
        tick();

        // LW 0x100, zero-wait slave
        drive_mem(1'b0, OP_LW, 32'h0000_0100, 32'h0);
        #1;
        check("lw_idle_stall", 32'(stallM), 32'd1);
        check("lw_idle_req", 32'(bus.data_req), 32'd0);
        tick();
        slave(1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("lw_addr_req", 32'(bus.data_req), 32'd1);
        check("lw_addr_stall", 32'(stallM), 32'd1);
        check("lw_addr", bus.data_addr, 32'h0000_0100);
        check("lw_size_wstrb_wr", {bus.data_wr, bus.data_size, bus.data_wstrb}, {25'd0, 1'b0, 2'd2, 4'b0000});
        tick();
        slave(1'b0, 1'b0, 32'h0);
        memenM = 1'b0;
        #1;
        check("lw_done_state", 32'(dbg_state), 32'd3);
        check("lw_done_stall", 32'(stallM), 32'd0);
        check("lw_done_rdata", readdataM, 32'hDEAD_BEEF);
        tick();

        // SB 0x103, addr_ok delayed 3 cycles
        drive_mem(1'b1, OP_SB, 32'h0000_0103, 32'h1234_5678);
        #1;
        check("sb_idle_stall", 32'(stallM), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            slave((i == 3), 1'b0, 32'h0);
            #1;
            check($sformatf("sb_req_%0d", i), 32'(bus.data_req), 32'd1);
            check($sformatf("sb_wdata_%0d", i), bus.data_wdata, 32'h7878_7878);
            check($sformatf("sb_fields_%0d", i), {bus.data_wr, bus.data_size, bus.data_wstrb},
                  {25'd0, 1'b1, 2'd0, 4'b1000});
        end
        check("sb_addr", bus.data_addr, 32'h0000_0103);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        check("sb_data_state", 32'(dbg_state), 32'd2);
        check("sb_data_req", 32'(bus.data_req), 32'd0);
        check("sb_data_stall", 32'(stallM), 32'd1);
        slave(1'b0, 1'b1, 32'h1111_2222);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        memenM = 1'b0;
        #1;
        check("sb_done_state", 32'(dbg_state), 32'd3);
        check("sb_done_stall", 32'(stallM), 32'd0);
        check("sb_keeps_rdata", readdataM, 32'hDEAD_BEEF);
        tick();

        // LH 0x201 (misaligned halfword)
        drive_mem(1'b0, OP_LH, 32'h0000_0201, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        check("lh_adel", 32'(adelM), 32'd1);
        check("lh_ades", 32'(adesM), 32'd0);
        check("lh_stall", 32'(stallM), 32'd0);
        flushM = 1'b1;
        #1;
        check("lh_adel_flushed", 32'(adelM), 32'd0);
        flushM = 1'b0;
        tick();
        check("lh_no_req", 32'(bus.data_req), 32'd0);
        check("lh_state", 32'(dbg_state), 32'd0);
        drive_mem(1'b1, OP_SW, 32'h0000_0102, 32'hAAAA_5555);
        #1;
        check("sw_mis_ades", {adesM, adelM, stallM}, 32'b100);
        tick();
        check("sw_mis_no_req", 32'(bus.data_req), 32'd0);
        memenM = 1'b0;
`else
        #1;
        check("lh_adel_off", {adelM, adesM}, 32'd0);
        check("lh_stall", 32'(stallM), 32'd1);
        tick();
        slave(1'b1, 1'b1, 32'hCAFE_F00D);
        #1;
        check("lh_aligned_addr", bus.data_addr, 32'h0000_0200);
        check("lh_size_wstrb", {bus.data_size, bus.data_wstrb}, {26'd0, 2'd1, 4'b0000});
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        check("lh_rdata", readdataM, 32'hCAFE_F00D);
        tick();
        drive_mem(1'b1, OP_SW, 32'h0000_0102, 32'hAAAA_5555);
        #1;
        check("sw_mis_ades_off", {adesM, adelM}, 32'd0);
        tick();
        slave(1'b1, 1'b1, 32'h0);
        #1;
        check("sw_mis_addr", bus.data_addr, 32'h0000_0100);
        check("sw_mis_wstrb", 32'(bus.data_wstrb), 32'hF);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        memenM = 1'b0;
        tick();
`endif

        // flush in ADDR before addr_ok
        drive_mem(1'b0, OP_LW, 32'h0000_0040, 32'h0);
        tick();
        flushM = 1'b1;
        #1;
        check("fla_req", 32'(bus.data_req), 32'd1);
        tick();
        flushM = 1'b0;
        memenM = 1'b0;
        #1;
        check("fla_req_drop", 32'(bus.data_req), 32'd0);
        check("fla_state", 32'(dbg_state), 32'd0);
        check("fla_stall", 32'(stallM), 32'd0);
        tick();

        // flush in DATA: transaction still completes
        drive_mem(1'b0, OP_LW, 32'h0000_0044, 32'h0);
        tick();
        slave(1'b1, 1'b0, 32'h0);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        flushM = 1'b1;
        tick();
        #1;
        check("fld_state", 32'(dbg_state), 32'd2);
        check("fld_stall", 32'(stallM), 32'd1);
        slave(1'b0, 1'b1, 32'h55AA_55AA);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        flushM = 1'b0;
        memenM = 1'b0;
        #1;
        check("fld_done", 32'(dbg_state), 32'd3);
        check("fld_rdata", readdataM, 32'h55AA_55AA);
        tick();

        // reset during DATA, then a late data_ok
        drive_mem(1'b0, OP_LW, 32'h0000_0080, 32'h0);
        tick();
        slave(1'b1, 1'b0, 32'h0);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        check("rstd_in_data", 32'(dbg_state), 32'd2);
        resetn = 1'b0;
        memenM = 1'b0;
        tick();
        check("rstd_state", 32'(dbg_state), 32'd0);
        check("rstd_outs", {bus.data_req, bus.data_wr, bus.data_size, bus.data_wstrb, stallM, adelM, adesM},
              32'd0);
        check("rstd_addr", bus.data_addr, 32'd0);
        check("rstd_rdata", readdataM, 32'd0);
        resetn = 1'b1;
        slave(1'b0, 1'b1, 32'hFFFF_FFFF);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        check("late_dok_rdata", readdataM, 32'd0);
        check("late_dok_state", 32'(dbg_state), 32'd0);

        // back-to-back SW 0x10 then LBU 0x11, zero-wait slave
        drive_mem(1'b1, OP_SW, 32'h0000_0010, 32'hA5A5_A5A5);
        tick();
        req_cyc1 = cyc;
        slave(1'b1, 1'b1, 32'h0);
        #1;
        check("b2b_sw_req", 32'(bus.data_req), 32'd1);
        check("b2b_sw_wstrb", 32'(bus.data_wstrb), 32'hF);
        check("b2b_sw_wdata", bus.data_wdata, 32'hA5A5_A5A5);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        check("b2b_sw_done", 32'(stallM), 32'd0);
        tick();
        drive_mem(1'b0, OP_LBU, 32'h0000_0011, 32'h0);
        #1;
        check("b2b_idle_req", 32'(bus.data_req), 32'd0);
        tick();
        req_cyc2 = cyc;
        slave(1'b1, 1'b1, 32'h0000_BB00);
        #1;
        check("b2b_lbu_req", 32'(bus.data_req), 32'd1);
        check("b2b_interval", 32'(req_cyc2 - req_cyc1), 32'd3);
        check("b2b_lbu_fields", {bus.data_size, bus.data_wstrb}, 32'd0);
        check("b2b_lbu_addr", bus.data_addr, 32'h0000_0011);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        memenM = 1'b0;
        #1;
        check("b2b_lbu_rdata", readdataM, 32'h0000_BB00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
